// File: rtl/lut_cfg_loader_if.sv
// Configuration / readback stream bundle for lut_cfg_loader.
// master = configuration controller side, slave = loader side.
interface lut_cfg_loader_if #(
   parameter int W = 8
);
   logic         cfg_valid;
   logic         cfg_ready;
   logic [W-1:0] cfg_data;
   logic         cfg_last;
   logic         cfg_par;
   logic         cfg_done;
   logic         cfg_err;
   logic         rb_req;
   logic         rb_valid;
   logic         rb_ready;
   logic [W-1:0] rb_data;
   logic         rb_last;

   modport master (
      output cfg_valid, cfg_data, cfg_last, cfg_par, rb_req, rb_ready,
      input  cfg_ready, cfg_done, cfg_err, rb_valid, rb_data, rb_last
   );

   modport slave (
      input  cfg_valid, cfg_data, cfg_last, cfg_par, rb_req, rb_ready,
      output cfg_ready, cfg_done, cfg_err, rb_valid, rb_data, rb_last
   );
endinterface

// File: rtl/lut_cfg_loader.sv
// Runtime-loadable K-input LUT: word-serial shadow load, atomic commit, mask readback.
// Define LUT_CFG_PARITY_EN to reject frames containing words with bad even parity.
module lut_cfg_loader #(
   parameter int K = 6,
   parameter int W = 8
) (
   input  logic              clk,
   input  logic              reset,
   lut_cfg_loader_if.slave   bus,
   input  logic [5:0]        in,
   output logic              out,
   output logic              mask_valid
);
   localparam int M  = 1 << K;
   localparam int N  = (M / W > 1) ? M / W : 1;
   localparam int SW = N * W;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT, READBACK} state_t;

   state_t         state, state_d;
   logic [CW-1:0]  cnt, cnt_d;
   logic [SW-1:0]  shadow;
   logic [M-1:0]   active;
   logic [SW-1:0]  active_ext;
   logic [W-1:0]   rb_word;
   logic           err_q;
   logic           accept;
   logic           at_last;
   logic           par_bad;
   logic           frame_err;
   logic           unused_bits;

   assign bus.cfg_ready = !reset && (state == IDLE || state == LOAD);
   assign accept        = bus.cfg_valid && bus.cfg_ready;
   assign at_last       = (cnt == CW'(N - 1));
   assign active_ext    = SW'(active);

`ifdef LUT_CFG_PARITY_EN
   logic par_err;
   logic word_bad;

   assign word_bad = ^{bus.cfg_data, bus.cfg_par};
   assign par_bad  = par_err || word_bad;

   // Sticky across the frame; the verdict is only taken on the closing word.
   always_ff @(posedge clk) begin
      if (reset)
         par_err <= 1'b0;
      else if (state_d == IDLE)
         par_err <= 1'b0;
      else if (accept && word_bad)
         par_err <= 1'b1;
   end
`else
   assign par_bad = 1'b0;
`endif

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      frame_err = 1'b0;
      case (state)
         IDLE, LOAD: begin
            if (accept) begin
               if (bus.cfg_last || at_last) begin
                  cnt_d = '0;
                  if ((bus.cfg_last != at_last) || par_bad) begin
                     frame_err = 1'b1;
                     state_d   = IDLE;
                  end else begin
                     state_d = COMMIT;
                  end
               end else begin
                  state_d = LOAD;
                  cnt_d   = cnt + 1'b1;
               end
            end else if (state == IDLE && bus.rb_req) begin
               state_d = READBACK;
               cnt_d   = '0;
            end
         end
         COMMIT: state_d = IDLE;
         READBACK: begin
            if (bus.rb_ready) begin
               if (at_last) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         shadow     <= '0;
         active     <= '0;
         mask_valid <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         err_q <= frame_err;
         if (accept) begin
            for (int unsigned i = 0; i < N; i++)
               if (cnt == CW'(i))
                  shadow[i*W +: W] <= bus.cfg_data;
         end
         if (frame_err)
            shadow <= '0;
         if (state == COMMIT) begin
            active     <= shadow[M-1:0];
            mask_valid <= 1'b1;
         end
      end
   end

   always_comb begin
      rb_word = '0;
      for (int unsigned i = 0; i < N; i++)
         if (cnt == CW'(i))
            rb_word = active_ext[i*W +: W];
   end

   assign bus.cfg_done = !reset && (state == COMMIT);
   assign bus.cfg_err  = err_q;
   assign bus.rb_valid = !reset && (state == READBACK);
   assign bus.rb_last  = bus.rb_valid && at_last;
   assign bus.rb_data  = bus.rb_valid ? rb_word : '0;

   assign out = mask_valid && active[in[K-1:0]];

   // Upper LUT inputs, unused parity bit and shadow padding beyond M are don't-cares.
   assign unused_bits = ^{in, bus.cfg_par, shadow};
endmodule

// File: tb/tb_lut_cfg_loader.sv
// Self-checking bench: three loader instances (K/W = 4/8, 6/16, 2/8) against a
// frame-level reference model, directed cases plus randomized frames and readbacks.
module tb_lut_cfg_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rst, cv, cl, cp, rq, rr;
   logic [15:0] cd  [3];
   logic [5:0]  lin [3];
   wire  [2:0]  crdy, cdone, cerr, rbv, rbl, lout, mv;
   wire  [15:0] rbd [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int KK = (g == 0) ? 4 : ((g == 1) ? 6 : 2);
      localparam int WW = (g == 1) ? 16 : 8;
      lut_cfg_loader_if #(.W(WW)) b ();
      assign b.cfg_valid = cv[g];
      assign b.cfg_data  = cd[g][WW-1:0];
      assign b.cfg_last  = cl[g];
      assign b.cfg_par   = cp[g];
      assign b.rb_req    = rq[g];
      assign b.rb_ready  = rr[g];
      assign crdy[g]     = b.cfg_ready;
      assign cdone[g]    = b.cfg_done;
      assign cerr[g]     = b.cfg_err;
      assign rbv[g]      = b.rb_valid;
      assign rbl[g]      = b.rb_last;
      assign rbd[g]      = 16'(b.rb_data);
      lut_cfg_loader #(.K(KK), .W(WW)) u_dut (
         .clk        (clk),
         .reset      (rst[g]),
         .bus        (b),
         .in         (lin[g]),
         .out        (lout[g]),
         .mask_valid (mv[g])
      );
   end

   int          npass = 0;
   int          nfail = 0;
   int          ntotal = 0;
   logic [63:0] model_act [3];
   bit          model_mv  [3];
   logic [15:0] wbuf [4];
   bit          pbad [4];

   function automatic int kof(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 6 : 2);
   endfunction
   function automatic int wof(input int d);
      return (d == 1) ? 16 : 8;
   endfunction
   function automatic int nof(input int d);
      int m = 1 << kof(d);
      return (m / wof(d) > 1) ? m / wof(d) : 1;
   endfunction
   function automatic logic [63:0] wm(input int d);
      return (64'd1 << wof(d)) - 64'd1;
   endfunction
   function automatic logic [63:0] mm(input int d);
      return (kof(d) == 6) ? '1 : ((64'd1 << (1 << kof(d))) - 64'd1);
   endfunction
   function automatic logic [63:0] exp_out(input int d, input logic [5:0] v);
      int idx = int'(v) & ((1 << kof(d)) - 1);
      return model_mv[d] ? ((model_act[d] >> idx) & 64'd1) : 64'd0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic out_rand(input int d, input string tag, input int cnt);
      for (int j = 0; j < cnt; j++) begin
         lin[d] = 6'($urandom_range(0, 63));
         #1;
         chk(tag, lout[d], exp_out(d, lin[d]));
      end
   endtask

   task automatic out_at(input int d, input logic [5:0] v, input string tag, input logic e);
      lin[d] = v;
      #1;
      chk(tag, lout[d], e);
   endtask

   task automatic reset_all();
      cv = '0; cl = '0; cp = '0; rq = '0; rr = '0;
      for (int d = 0; d < 3; d++) begin
         cd[d] = '0;
         lin[d] = '0;
      end
      rst = '1;
      #1;
      chk("rst_cfg_ready_low", crdy, 3'b000);
      tick();
      rst = '0;
      #1;
      chk("rst_mask_valid", mv, 3'b000);
      chk("rst_cfg_done", cdone, 3'b000);
      chk("rst_cfg_err", cerr, 3'b000);
      chk("rst_rb_valid", rbv, 3'b000);
      chk("rst_rb_last", rbl, 3'b000);
      chk("rst_rb_data", {rbd[0], rbd[1], rbd[2]}, 64'd0);
      chk("rst_cfg_ready_high", crdy, 3'b111);
      chk("rst_out", lout, 3'b000);
      for (int d = 0; d < 3; d++) begin
         model_act[d] = '0;
         model_mv[d]  = 1'b0;
      end
   endtask

   // A frame of n words, cfg_last only on the final word when 'last' is set.
   task automatic send_frame(input int d, input int n, input bit last, input bit coll);
      int          nw = nof(d);
      int          w  = wof(d);
      bit          ok;
      logic [63:0] nm = '0;
      ok = (n == nw) && last;
      for (int i = 0; i < n; i++)
         nm |= (64'(wbuf[i]) & wm(d)) << (i * w);
      nm &= mm(d);
`ifdef LUT_CFG_PARITY_EN
      for (int i = 0; i < n; i++)
         if (pbad[i]) ok = 1'b0;
`endif
      for (int i = 0; i < n; i++) begin
         if (!coll && $urandom_range(0, 3) == 0) begin
            cv[d] = 1'b0;
            tick();
            chk("gap_no_done", cdone[d], 1'b0);
         end
         cv[d] = 1'b1;
         cd[d] = wbuf[i];
         cl[d] = (i == n - 1) && last;
         cp[d] = (^(64'(wbuf[i]) & wm(d))) ^ pbad[i];
         if (coll && i == 0) rq[d] = 1'b1;
         #1;
         chk("load_cfg_ready", crdy[d], 1'b1);
         tick();
         rq[d] = 1'b0;
         if (coll && i == 0) chk("coll_no_readback", rbv[d], 1'b0);
      end
      cv[d] = 1'b0;
      cl[d] = 1'b0;
      if (ok) begin
         chk("commit_done", cdone[d], 1'b1);
         chk("commit_no_err", cerr[d], 1'b0);
         chk("commit_not_ready", crdy[d], 1'b0);
         out_rand(d, "commit_out_old", 1);
         tick();
         chk("done_one_cycle", cdone[d], 1'b0);
         model_act[d] = nm;
         model_mv[d]  = 1'b1;
         chk("commit_mask_valid", mv[d], 1'b1);
         out_rand(d, "commit_out_new", 3);
      end else begin
         chk("reject_err", cerr[d], 1'b1);
         chk("reject_no_done", cdone[d], 1'b0);
         tick();
         chk("err_one_cycle", cerr[d], 1'b0);
         chk("reject_no_done2", cdone[d], 1'b0);
         chk("reject_mask_valid", mv[d], model_mv[d]);
         out_rand(d, "reject_out_kept", 2);
      end
   endtask

   task automatic readback(input int d, input logic [31:0] pat);
      int nw = nof(d);
      int w  = wof(d);
      int k  = 0;
      int j  = 0;
      cv[d] = 1'b0;
      rq[d] = 1'b1;
      tick();
      rq[d] = 1'b0;
      while (k < nw && j < 100) begin
         rr[d] = (j < 32) ? pat[j] : 1'b1;
         #1;
         chk("rb_valid", rbv[d], 1'b1);
         chk("rb_data", rbd[d], (model_act[d] >> (k * w)) & wm(d));
         chk("rb_last", rbl[d], k == nw - 1);
         chk("rb_cfg_ready", crdy[d], 1'b0);
         tick();
         if (rr[d]) k++;
         j++;
      end
      rr[d] = 1'b0;
      chk("rb_word_count", k, nw);
      chk("rb_back_idle", rbv[d], 1'b0);
      chk("rb_ready_again", crdy[d], 1'b1);
   endtask

   task automatic clr_pbad();
      for (int i = 0; i < 4; i++) pbad[i] = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_pbad();
      reset_all();

      // K=4/W=8: 0x6996
      wbuf[0] = 16'h96; wbuf[1] = 16'h69;
      send_frame(0, 2, 1'b1, 1'b0);
      chk("tp1_mask_valid", mv[0], 1'b1);
      out_at(0, 6'b000001, "tp1_in1", 1'b1);
      out_at(0, 6'b000011, "tp1_in3", 1'b0);
      out_at(0, 6'b110011, "tp1_upper_ignored", 1'b0);

      // early cfg_last
      wbuf[0] = 16'hAA;
      send_frame(0, 1, 1'b1, 1'b0);
      out_at(0, 6'b000001, "tp2_mask_kept", 1'b1);

      // missing cfg_last on the final word
      wbuf[0] = 16'h11; wbuf[1] = 16'h22;
      send_frame(0, 2, 1'b0, 1'b0);

      // parity frame after a zero mask
      wbuf[0] = 16'h00; wbuf[1] = 16'h00;
      send_frame(0, 2, 1'b1, 1'b0);
      wbuf[0] = 16'h96; wbuf[1] = 16'h69; pbad[0] = 1'b1;
      send_frame(0, 2, 1'b1, 1'b0);
      clr_pbad();
`ifdef LUT_CFG_PARITY_EN
      out_at(0, 6'b000001, "par_rejected", 1'b0);
`else
      out_at(0, 6'b000001, "par_ignored", 1'b1);
`endif

      // rb_req colliding with an IDLE accept
      wbuf[0] = 16'h12; wbuf[1] = 16'h34;
      send_frame(0, 2, 1'b1, 1'b1);
      readback(0, $urandom);

      // K=6/W=16 four-word frame and stalled readback
      wbuf[0] = 16'h0001; wbuf[1] = 16'h0000; wbuf[2] = 16'h0000; wbuf[3] = 16'h8000;
      send_frame(1, 4, 1'b1, 1'b0);
      readback(1, 32'b11101);
      out_at(1, 6'd0, "tp3_in0", 1'b1);
      out_at(1, 6'd63, "tp3_in63", 1'b1);
      out_at(1, 6'd5, "tp3_in5", 1'b0);

      // K=2/W=8 single-word frame
      wbuf[0] = 16'h08;
      send_frame(2, 1, 1'b1, 1'b0);
      out_at(2, 6'd3, "tp4_in3", 1'b1);
      out_at(2, 6'd2, "tp4_in2", 1'b0);
      readback(2, 32'hFFFF_FFFF);

      // reset together with a closing word on the N=1 instance
      cv[2] = 1'b1; cd[2] = 16'h0F; cl[2] = 1'b1; cp[2] = 1'b0; rst[2] = 1'b1;
      tick();
      rst[2] = 1'b0; cv[2] = 1'b0; cl[2] = 1'b0;
      model_act[2] = '0; model_mv[2] = 1'b0;
      chk("rst2_no_done", cdone[2], 1'b0);
      chk("rst2_mask_valid", mv[2], 1'b0);
      out_at(2, 6'd3, "rst2_out", 1'b0);
      tick();
      chk("rst2_no_err", cerr[2], 1'b0);
      chk("rst2_no_done_late", cdone[2], 1'b0);
      chk("rst2_mask_valid_late", mv[2], 1'b0);

      // reset mid-frame on the two-word instance
      cv[0] = 1'b1; cd[0] = 16'h55; cl[0] = 1'b0; cp[0] = 1'b0;
      tick();
      cv[0] = 1'b0; rst[0] = 1'b1;
      #1;
      chk("rst0_ready_low", crdy[0], 1'b0);
      tick();
      rst[0] = 1'b0;
      model_act[0] = '0; model_mv[0] = 1'b0;
      chk("rst0_no_err", cerr[0], 1'b0);
      chk("rst0_mask_valid", mv[0], 1'b0);
      out_rand(0, "rst0_out", 2);
      tick();
      chk("rst0_no_err_late", cerr[0], 1'b0);
      chk("rst0_no_done_late", cdone[0], 1'b0);

      // randomized frames and readbacks
      for (int d = 0; d < 3; d++) begin
         for (int f = 0; f < 25; f++) begin
            int  n = $urandom_range(1, nof(d));
            bit  last = (n < nof(d)) ? 1'b1 : ($urandom_range(0, 4) != 0);
            for (int i = 0; i < 4; i++) begin
               wbuf[i] = 16'($urandom);
               pbad[i] = ($urandom_range(0, 7) == 0);
            end
            send_frame(d, n, last, ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 2) == 0) readback(d, $urandom);
         end
      end
      clr_pbad();

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule
